// File: rtl/fft_common_pkg.sv
// Shared constants and helpers for the FFT datapath building blocks.
package fft_common_pkg;

    // Upper bound on the depth of a dff_pipe_async_reset instance.
    localparam int DFF_PIPE_MAX_DEPTH = 64;

    // Bits needed to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_async_high_reset_en.sv
// Single pipeline stage: a W-bit register with asynchronous active-high
// reset, synchronous clear and clock enable. Clear beats enable.
module dff_async_high_reset_en #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register with priority rst > clr > en > hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_pipe_async_reset.sv
// Multi-lane delay pipeline with enable, valid tag, synchronous flush and
// asynchronous active-high reset. Used to balance FFT datapath branches by a
// fixed number of enabled cycles.
//
// Optional feature macro: DFF_PIPE_FILL_CNT_EN
//   When defined, adds the fill_cnt / primed outputs that track how many
//   valid samples are currently in flight. When undefined, neither port nor
//   any counter logic exists; pipeline behaviour is identical either way.
module dff_pipe_async_reset
    import fft_common_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 2,
    parameter int DEPTH      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          vld_in,
    input  logic [LANES*DATA_WIDTH-1:0]   D,
    output logic [LANES*DATA_WIDTH-1:0]   Q,
`ifdef DFF_PIPE_FILL_CNT_EN
    output logic [cnt_width(DEPTH)-1:0]   fill_cnt,
    output logic                          primed,
`endif
    output logic                          vld_out
);

    localparam int WORD_W  = LANES * DATA_WIDTH;
    localparam int STAGE_W = WORD_W + 1;

    // Reject illegal depths at elaboration time.
    generate
        if (DEPTH < 1 || DEPTH > DFF_PIPE_MAX_DEPTH) begin : g_bad_depth
            $error("dff_pipe_async_reset: DEPTH must be in 1..64");
        end
    endgenerate

    // Stage outputs; each entry packs {vld, data} with vld in the MSB.
    logic [STAGE_W-1:0] stage_q [DEPTH];

    // Chain of DEPTH identical stages; stage 0 captures the input word.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [STAGE_W-1:0] stage_d;
            if (gi == 0) begin : g_head
                assign stage_d = {vld_in, D};
            end else begin : g_body
                assign stage_d = stage_q[gi-1];
            end

            dff_async_high_reset_en #(
                .W (STAGE_W)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (en),
                .clr (flush),
                .d   (stage_d),
                .q   (stage_q[gi])
            );
        end
    endgenerate

    // The last stage drives the outputs directly; no logic after the flop.
    assign Q       = stage_q[DEPTH-1][WORD_W-1:0];
    assign vld_out = stage_q[DEPTH-1][STAGE_W-1];

`ifdef DFF_PIPE_FILL_CNT_EN
    localparam int CNT_W = cnt_width(DEPTH);

    logic [CNT_W-1:0] fill_cnt_reg;
    logic [CNT_W-1:0] fill_cnt_next;
    logic             primed_reg;
    logic             primed_next;

    // Count update: entering valid minus leaving valid. The result always
    // equals the number of valid stages, so it stays within 0..DEPTH.
    always_comb begin
        fill_cnt_next = fill_cnt_reg;
        if (flush) begin
            fill_cnt_next = '0;
        end else if (en) begin
            fill_cnt_next = fill_cnt_reg + CNT_W'(vld_in) - CNT_W'(vld_out);
        end
        primed_next = (fill_cnt_next == CNT_W'(DEPTH));
    end

    // Counter and primed flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt_reg <= '0;
            primed_reg   <= 1'b0;
        end else begin
            fill_cnt_reg <= fill_cnt_next;
            primed_reg   <= primed_next;
        end
    end

    assign fill_cnt = fill_cnt_reg;
    assign primed   = primed_reg;
`endif

endmodule

// File: tb/tb_dff_pipe_async_reset.sv
// Self-checking bench for dff_pipe_async_reset: a DEPTH=3 two-lane instance
// checked against a queue-based scoreboard, plus a DEPTH=1 instance run with
// random stimulus against a single-register model.
module tb_dff_pipe_async_reset;

    localparam int DEPTH = 3;
    localparam int DW    = 16;
    localparam int LN    = 2;
    localparam int WW    = DW * LN;

    logic          clk;
    logic          rst;
    logic          en;
    logic          flush;
    logic          vld_in;
    logic [WW-1:0] d;
    logic [WW-1:0] q;
    logic          vld_out;
`ifdef DFF_PIPE_FILL_CNT_EN
    logic [1:0]    fill_cnt;
    logic          primed;
    logic          fill1;
    logic          primed1;
`endif

    logic          en1;
    logic          flush1;
    logic          vld1;
    logic [7:0]    d1;
    logic [7:0]    q1;
    logic          vo1;

    int n_checks;
    int n_pass;

    // Scoreboard: one entry per stage, front is the last stage.
    logic [WW:0] pipe_q[$];
    logic [8:0]  exp1;

    dff_pipe_async_reset #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .vld_in   (vld_in),
        .D        (d),
        .Q        (q),
`ifdef DFF_PIPE_FILL_CNT_EN
        .fill_cnt (fill_cnt),
        .primed   (primed),
`endif
        .vld_out  (vld_out)
    );

    dff_pipe_async_reset #(
        .DATA_WIDTH (8),
        .LANES      (1),
        .DEPTH      (1)
    ) dut1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en1),
        .flush    (flush1),
        .vld_in   (vld1),
        .D        (d1),
        .Q        (q1),
`ifdef DFF_PIPE_FILL_CNT_EN
        .fill_cnt (fill1),
        .primed   (primed1),
`endif
        .vld_out  (vo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe_q = {};
        for (int i = 0; i < DEPTH; i++) pipe_q.push_back('0);
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < pipe_q.size(); i++) c += int'(pipe_q[i][WW]);
        return c;
    endfunction

    // Compare the DEPTH=3 outputs against the scoreboard front entry.
    task automatic check_outputs(input string tag);
        logic [WW:0] e;
        e = pipe_q[0];
        check_eq({tag, ".q"}, 64'(q), 64'(e[WW-1:0]));
        check_eq({tag, ".vld"}, 64'(vld_out), 64'(e[WW]));
`ifdef DFF_PIPE_FILL_CNT_EN
        check_eq({tag, ".fill"}, 64'(fill_cnt), 64'(model_count()));
        check_eq({tag, ".primed"}, 64'(primed), 64'(model_count() == DEPTH));
`endif
    endtask

    // One clock: drive at negedge, update the scoreboard at posedge,
    // compare 1 time unit later, return at the next negedge.
    task automatic step(input string tag, input logic e, input logic f,
                        input logic v, input logic [WW-1:0] dd);
        en = e; flush = f; vld_in = v; d = dd;
        @(posedge clk);
        if (f) begin
            model_reset();
        end else if (e) begin
            void'(pipe_q.pop_front());
            pipe_q.push_back({v, dd});
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; en = 1'b1; flush = 1'b0; vld_in = 1'b1; d = 32'hFFFF_FFFF;
        en1 = 1'b0; flush1 = 1'b0; vld1 = 1'b0; d1 = '0;
        model_reset();

        // Reset dominates an enabled valid input.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold.q", 64'(q), 64'd0);
            check_eq("rst_hold.vld", 64'(vld_out), 64'd0);
            @(negedge clk);
        end
        rst = 1'b0;

        // Latency: single valid sample out after 3 enabled edges.
        step("lat", 1'b1, 1'b0, 1'b1, 32'h1234_ABCD);
        for (int i = 0; i < 4; i++) step("lat", 1'b1, 1'b0, 1'b0, 32'h0);

        // Stall: 4 disabled cycles after the first edge.
        step("stall", 1'b1, 1'b0, 1'b1, 32'h5555_AAAA);
        for (int i = 0; i < 4; i++) step("stall", 1'b0, 1'b0, 1'b1, 32'($urandom));
        for (int i = 0; i < 4; i++) step("stall", 1'b1, 1'b0, 1'b0, 32'h0);

        // Flush with en=1 and a valid offer; offer must never appear,
        // and the very next capture must be accepted.
        step("fill", 1'b1, 1'b0, 1'b1, 32'h1111_0001);
        step("fill", 1'b1, 1'b0, 1'b1, 32'h2222_0002);
        step("fill", 1'b1, 1'b0, 1'b1, 32'h3333_0003);
        step("flush", 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step("postflush", 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
        for (int i = 0; i < 4; i++) step("postflush", 1'b1, 1'b0, 1'b0, 32'h0);

        // Fill counter saturation and drain.
        for (int i = 0; i < 5; i++) step("cnt_up", 1'b1, 1'b0, 1'b1, 32'(i + 100));
        for (int i = 0; i < 4; i++) step("cnt_dn", 1'b1, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset mid-cycle with data in flight.
        step("inflight", 1'b1, 1'b0, 1'b1, 32'hA5A5_5A5A);
        step("inflight", 1'b1, 1'b0, 1'b1, 32'h0F0F_F0F0);
        step("inflight", 1'b1, 1'b0, 1'b1, 32'h7777_8888);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst.q", 64'(q), 64'd0);
        check_eq("async_rst.vld", 64'(vld_out), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("after_rst", 1'b1, 1'b0, 1'(i == 0), 32'h4242_0000 + 32'(i));

        // Random traffic on the DEPTH=3 instance.
        for (int i = 0; i < 300; i++) begin
            step("rand3", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                 1'($urandom), 32'($urandom));
        end
        en = 1'b0; flush = 1'b0; vld_in = 1'b0;

        // DEPTH=1: single-register model, random stimulus.
        exp1 = '0;
        for (int i = 0; i < 10000; i++) begin
            en1    = 1'($urandom);
            flush1 = 1'($urandom_range(0, 31) == 0);
            vld1   = 1'($urandom);
            d1     = 8'($urandom);
            @(posedge clk);
            if (flush1) exp1 = '0;
            else if (en1) exp1 = {vld1, d1};
            #1;
            check_eq("d1.q", 64'(q1), 64'(exp1[7:0]));
            check_eq("d1.vld", 64'(vo1), 64'(exp1[8]));
`ifdef DFF_PIPE_FILL_CNT_EN
            check_eq("d1.fill", 64'(fill1), 64'(exp1[8]));
            check_eq("d1.primed", 64'(primed1), 64'(exp1[8]));
`endif
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
